// File: rtl/spi_pkg.sv
// Shared SPI link definitions: peripheral FSM encoding and the default
// word lengths used by both the controller and the peripheral ends.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX,
        LOAD,
        TX,
        TRAIL
    } spi_periph_state_t;

    localparam int SPI_LENGTH_SEND     = 8;
    localparam int SPI_LENGTH_RECIEVED = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with rise/fall
// detection on the synchronised value. The reset value lets idle-high
// lines (SCK, CS) come out of reset without a spurious edge.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;

    // Shift the raw input through the synchroniser and keep the previous synced value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg <= {SYNC_STAGES{RESET_VALUE}};
            prev_reg <= RESET_VALUE;
        end else begin
            sync_reg <= (sync_reg << 1) | SYNC_STAGES'(din);
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign level = sync_reg[SYNC_STAGES-1];
    assign rise  = level & ~prev_reg;
    assign fall  = ~level & prev_reg;

endmodule

// File: rtl/spi_peripheral.sv
// SPI responder for one chip-select line. SCK/COPI/CS are oversampled on
// clk; the request word is shifted in LSB first on SCK rises, then the
// response word is shifted out LSB first, changing CIPO on SCK falls.
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int LENGTH_SEND     = SPI_LENGTH_SEND,
    parameter int LENGTH_RECIEVED = SPI_LENGTH_RECIEVED,
    parameter int LENGTH_COUNT    = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int IDLE_TIMEOUT    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       SCK,
    input  logic                       COPI,
    input  logic                       CS,
    output logic                       CIPO,
    output logic                       CIPO_oe,
    output logic [LENGTH_SEND-1:0]     rx_data,
    output logic                       rx_valid,
    input  logic [LENGTH_RECIEVED-1:0] tx_data,
    output logic                       busy,
    output logic                       frame_error
);

    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [LENGTH_COUNT-1:0] LAST_RX   = LENGTH_COUNT'(LENGTH_SEND - 1);
    localparam logic [LENGTH_COUNT-1:0] LAST_TX   = LENGTH_COUNT'(LENGTH_RECIEVED - 1);
    localparam logic [IDLE_W-1:0]       LAST_IDLE = IDLE_W'(IDLE_TIMEOUT - 1);

    logic sck_sync, sck_rise, sck_fall;
    logic cs_sync, cs_rise_unused, cs_fall_unused;
    logic copi_sync, copi_rise_unused, copi_fall_unused;

    spi_periph_state_t          state_reg;
    logic [LENGTH_COUNT-1:0]    bit_cnt_reg;
    logic [LENGTH_COUNT-1:0]    bit_cnt_next;
    logic [IDLE_W-1:0]          idle_cnt_reg;
    logic [LENGTH_SEND-1:0]     rx_shift_reg;
    logic [LENGTH_SEND-1:0]     rx_shift_next;
    logic [LENGTH_RECIEVED-1:0] tx_shift_reg;
    logic [LENGTH_RECIEVED-1:0] tx_shift_next;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_sck (
        .clk(clk), .rst(rst), .din(SCK),
        .level(sck_sync), .rise(sck_rise), .fall(sck_fall)
    );

    // CS is acted on as a level: a release that lands during LOAD must
    // still abort in TX, which a one-cycle edge pulse would miss.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .din(CS),
        .level(cs_sync), .rise(cs_rise_unused), .fall(cs_fall_unused)
    );

    // COPI is only sampled on SCK rises, so its own edges are irrelevant.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_copi (
        .clk(clk), .rst(rst), .din(COPI),
        .level(copi_sync), .rise(copi_rise_unused), .fall(copi_fall_unused)
    );

    // Saturating bit count and the next shift-register images
    always_comb begin
        bit_cnt_next  = (bit_cnt_reg == '1) ? bit_cnt_reg : bit_cnt_reg + LENGTH_COUNT'(1);
        rx_shift_next = {copi_sync, rx_shift_reg[LENGTH_SEND-1:1]};
        tx_shift_next = tx_shift_reg >> 1;
    end

    // Frame FSM with all outputs registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= '0;
            idle_cnt_reg <= '0;
            rx_shift_reg <= '0;
            tx_shift_reg <= '0;
            CIPO         <= 1'b0;
            CIPO_oe      <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            busy         <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            case (state_reg)
                IDLE: begin
                    CIPO         <= 1'b0;
                    CIPO_oe      <= 1'b0;
                    bit_cnt_reg  <= '0;
                    idle_cnt_reg <= '0;
                    if (!cs_sync) begin
                        state_reg <= RX;
                        busy      <= 1'b1;
                    end
                end
                RX: begin
                    if (cs_sync) begin
                        state_reg   <= IDLE;
                        busy        <= 1'b0;
                        frame_error <= 1'b1;
                        CIPO        <= 1'b0;
                        CIPO_oe     <= 1'b0;
                    end else if (sck_rise) begin
                        rx_shift_reg <= rx_shift_next;
                        bit_cnt_reg  <= bit_cnt_next;
                        if (bit_cnt_reg == LAST_RX) begin
                            // rx_valid is high during LOAD, the cycle tx_data is taken
                            rx_data   <= rx_shift_next;
                            rx_valid  <= 1'b1;
                            state_reg <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    tx_shift_reg <= tx_data;
                    CIPO         <= tx_data[0];
                    CIPO_oe      <= 1'b1;
                    bit_cnt_reg  <= '0;
                    state_reg    <= TX;
                end
                TX: begin
                    if (cs_sync) begin
                        state_reg   <= IDLE;
                        busy        <= 1'b0;
                        frame_error <= 1'b1;
                        CIPO        <= 1'b0;
                        CIPO_oe     <= 1'b0;
                    end else if (sck_rise) begin
                        bit_cnt_reg <= bit_cnt_next;
                        if (bit_cnt_reg == LAST_TX) begin
                            state_reg    <= TRAIL;
                            CIPO         <= 1'b0;
                            CIPO_oe      <= 1'b0;
                            idle_cnt_reg <= '0;
                        end
                    end else if (sck_fall && (bit_cnt_reg != '0)) begin
                        // A zero count means no TX rise yet: that fall closed the RX phase
                        tx_shift_reg <= tx_shift_next;
                        CIPO         <= tx_shift_next[0];
                    end
                end
                TRAIL: begin
                    if (cs_sync || (sck_sync && (idle_cnt_reg == LAST_IDLE))) begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end else if (sck_sync) begin
                        idle_cnt_reg <= idle_cnt_reg + IDLE_W'(1);
                    end else begin
                        idle_cnt_reg <= '0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_peripheral.sv
// Bench for spi_peripheral: drives an SPI controller (SCK = clk/10, LSB
// first, SCK idles high) and checks the words received and returned
// against a simple word-level model of the link.
module tb_spi_peripheral;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       SCK = 1'b1;
    logic       COPI = 1'b0;
    logic       CS = 1'b1;
    logic       CIPO, CIPO_oe, rx_valid, busy, frame_error;
    logic [7:0] rx_data;
    logic [7:0] tx_data;

    logic       invert_mode = 1'b0;
    logic [7:0] tx_word = 8'h00;

    int total = 0;
    int bad = 0;
    int rxv_cnt = 0;
    int ferr_cnt = 0;

    // Model state: last complete request word the peripheral should hold
    logic [7:0] exp_rx = 8'h00;

    spi_peripheral dut (
        .clk(clk), .rst(rst), .SCK(SCK), .COPI(COPI), .CS(CS),
        .CIPO(CIPO), .CIPO_oe(CIPO_oe), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .busy(busy), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    // User logic behind the peripheral: fixed word or echo of ~rx_data
    assign tx_data = invert_mode ? ~rx_data : tx_word;

    // Count single-cycle status pulses
    always @(negedge clk) begin
        if (rx_valid)    rxv_cnt++;
        if (frame_error) ferr_cnt++;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cs_select();
        CS = 1'b0;
        clks(10);
    endtask

    task automatic cs_release();
        CS = 1'b1;
        clks(10);
    endtask

    // Controller: n_rx request bits, n_tx response bits, optional extra pulse, then pause
    task automatic spi_bits(input logic [7:0] req, input int n_rx, input int n_tx,
                            input bit extra, output logic [7:0] cap, output bit oe_ok);
        cap   = 8'h00;
        oe_ok = 1'b1;
        for (int i = 0; i < n_rx; i++) begin
            SCK = 1'b0; COPI = req[i]; clks(5);
            SCK = 1'b1; clks(5);
        end
        for (int i = 0; i < n_tx; i++) begin
            SCK = 1'b0; clks(5);
            cap[i] = CIPO;
            if (!CIPO_oe) oe_ok = 1'b0;
            SCK = 1'b1; clks(5);
        end
        if (extra) begin
            SCK = 1'b0; clks(5);
            SCK = 1'b1; clks(5);
        end
        clks(50);
    endtask

    task automatic full_frame(input string tag, input logic [7:0] req,
                              input logic [7:0] rsp_exp, input bit extra);
        int v0, e0;
        logic [7:0] cap;
        bit oe_ok;
        v0 = rxv_cnt;
        e0 = ferr_cnt;
        spi_bits(req, 8, 8, extra, cap, oe_ok);
        exp_rx = req;
        $display("frame %s req=0x%02h rsp=0x%02h rx_data=0x%02h", tag, req, cap, rx_data);
        check_eq({tag, "_rx_data"}, rx_data, exp_rx);
        check_eq({tag, "_rsp"}, cap, rsp_exp);
        check_eq({tag, "_rx_valid_pulses"}, rxv_cnt - v0, 1);
        check_eq({tag, "_frame_error_pulses"}, ferr_cnt - e0, 0);
        check_eq({tag, "_cipo_oe"}, oe_ok, 1);
    endtask

    initial begin
        int v0, e0, n;
        logic [7:0] cap, req, rsp;
        bit oe_ok, hold;

        // Reset state
        clks(3);
        check_eq("rst_cipo", CIPO, 0);
        check_eq("rst_cipo_oe", CIPO_oe, 0);
        check_eq("rst_rx_data", rx_data, 0);
        check_eq("rst_rx_valid", rx_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_frame_error", frame_error, 0);
        rst = 1'b1;
        clks(5);

        // T1: single frame
        tx_word = 8'h3C;
        cs_select();
        check_eq("t1_busy_selected", busy, 1);
        full_frame("t1", 8'hA5, 8'h3C, 1'b0);
        cs_release();
        check_eq("t1_busy_released", busy, 0);

        // T2: back-to-back frames with CS held low, echoing ~rx_data
        invert_mode = 1'b1;
        cs_select();
        full_frame("t2_0", 8'h00, 8'hFF, 1'b0);
        full_frame("t2_1", 8'hFF, 8'h00, 1'b0);
        full_frame("t2_2", 8'h81, 8'h7E, 1'b0);
        full_frame("t2_3", 8'h7E, 8'h81, 1'b0);
        cs_release();
        invert_mode = 1'b0;

        // T3: release after 3 request bits
        v0 = rxv_cnt; e0 = ferr_cnt;
        cs_select();
        spi_bits(8'h5A, 3, 0, 1'b0, cap, oe_ok);
        cs_release();
        $display("frame t3 partial req=0x5a bits=3 rx_data=0x%02h", rx_data);
        check_eq("t3_frame_error_pulses", ferr_cnt - e0, 1);
        check_eq("t3_rx_valid_pulses", rxv_cnt - v0, 0);
        check_eq("t3_rx_data_kept", rx_data, exp_rx);
        tx_word = 8'($urandom);
        cs_select();
        full_frame("t3_next", 8'h11, tx_word, 1'b0);
        cs_release();

        // T4: release after 4 response bits
        tx_word = 8'h5C;
        v0 = rxv_cnt; e0 = ferr_cnt;
        cs_select();
        spi_bits(8'hE7, 8, 4, 1'b0, cap, oe_ok);
        exp_rx = 8'hE7;
        CS = 1'b1;
        n = 0;
        while (CIPO_oe && n < 10) begin
            clks(1);
            n++;
        end
        $display("frame t4 partial req=0xe7 rsp_bits=0x%01h oe_off_after=%0d", cap[3:0], n);
        check_eq("t4_rsp_low_nibble", cap[3:0], 4'hC);
        check_eq("t4_cipo_oe_off", CIPO_oe, 0);
        check_eq("t4_oe_latency_ok", (n <= 4), 1);
        clks(10);
        check_eq("t4_frame_error_pulses", ferr_cnt - e0, 1);
        check_eq("t4_rx_valid_pulses", rxv_cnt - v0, 1);
        check_eq("t4_rx_data", rx_data, exp_rx);
        check_eq("t4_busy_idle", busy, 0);

        // T5: extra trailing SCK pulse, then a frame that must not be shifted
        cs_select();
        tx_word = 8'($urandom);
        full_frame("t5_extra", 8'h96, tx_word, 1'b1);
        tx_word = 8'($urandom);
        full_frame("t5_next", 8'hC3, tx_word, 1'b0);
        cs_release();

        // T6: reset in the middle of the response phase
        e0 = ferr_cnt;
        tx_word = 8'hB1;
        cs_select();
        spi_bits(8'h99, 8, 3, 1'b0, cap, oe_ok);
        rst = 1'b0;
        exp_rx = 8'h00;
        #1;
        $display("frame t6 reset mid-tx rx_data=0x%02h oe=%0b", rx_data, CIPO_oe);
        check_eq("t6_cipo", CIPO, 0);
        check_eq("t6_cipo_oe", CIPO_oe, 0);
        check_eq("t6_rx_data", rx_data, exp_rx);
        check_eq("t6_rx_valid", rx_valid, 0);
        check_eq("t6_busy", busy, 0);
        check_eq("t6_frame_error", frame_error, 0);
        CS = 1'b1;
        clks(5);
        rst = 1'b1;
        clks(5);
        check_eq("t6_no_frame_error", ferr_cnt - e0, 0);
        tx_word = 8'h24;
        cs_select();
        full_frame("t6_next", 8'h42, 8'h24, 1'b0);
        cs_release();

        // Random frames, CS randomly held or released between them
        for (int k = 0; k < 8; k++) begin
            req     = 8'($urandom);
            rsp     = 8'($urandom);
            tx_word = rsp;
            hold    = 1'($urandom_range(0, 1));
            if (CS) cs_select();
            full_frame($sformatf("rnd%0d", k), req, rsp, 1'b0);
            if (!hold) cs_release();
        end
        if (!CS) cs_release();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
